hbm_init_sequencer: RTL and testbench
=====================================

// Module: hbm_init_sequencer
// PURPOSE
//  Power-up/recovery sequencer for the HBM subsystem: enables the 100 MHz HBM reference
//  clock, waits for it to settle, holds HBM reset, waits for APB calibration complete,
//  and retries on calibration timeout. Sits between host control (start/stop) and the
//  HBM clock generator / HBM IP reset, on a free-running control clock.
// PARAMETERS
//  CLK_STABLE_CYCLES   256      cycles hbm_clk_en is high before reset hold begins (>=1)
//  RST_HOLD_CYCLES     64       cycles hbm_rst_n held low with clock running (>=1)
//  CAL_TIMEOUT_CYCLES  1048576  cycles to wait for calibration per attempt (>=1)
//  MAX_RETRIES         3        extra attempts after first timeout (0..15)
//  CNT_W               24       internal down-counter width; must hold max of the above
// PORTS
//  clk           in   1  control clock; all logic in this domain
//  rst           in   1  asynchronous, active-high reset
//  start         in   1  1-cycle pulse: begin sequence (honoured in IDLE only)
//  stop          in   1  level/pulse: abort to IDLE from any state
//  apb_complete  in   1  HBM calibration done, asynchronous; 2-FF synchronised internally
//  cattrip       in   1  HBM catastrophic temperature trip, asynchronous; 2-FF synchronised
//  hbm_clk_en    out  1  enables HBM clock generator
//  hbm_rst_n     out  1  HBM IP reset, active-low
//  ready         out  1  HBM calibrated and usable
//  error         out  1  sequencer in FAIL
//  err_code      out  2  0 none, 1 calibration retries exhausted, 2 cattrip
//  retry_cnt     out  4  retries consumed in current sequence
//  state_o       out  3  IDLE=0 CLK_ON=1 RST_HOLD=2 CAL_WAIT=3 READY=4 FAIL=5
// BEHAVIOUR
//  - All outputs registered. Reset (async assert, sync release): state IDLE, hbm_clk_en=0,
//    hbm_rst_n=0, ready=0, error=0, err_code=0, retry_cnt=0, counter=0, sync FFs=0.
//  - IDLE: clk_en=0, rst_n=0. start=1 & stop=0 -> CLK_ON next edge; retry_cnt<=0,
//    err_code<=0, counter<=CLK_STABLE_CYCLES-1. start ignored in all other states.
//  - CLK_ON: clk_en=1, rst_n=0; counter decrements; at 0 -> RST_HOLD, load RST_HOLD_CYCLES-1.
//    State lasts exactly CLK_STABLE_CYCLES cycles.
//  - RST_HOLD: clk_en=1, rst_n=0 for exactly RST_HOLD_CYCLES cycles -> CAL_WAIT,
//    load CAL_TIMEOUT_CYCLES-1.
//  - CAL_WAIT: clk_en=1, rst_n=1. Synced apb_complete=1 -> READY (ready=1 on the edge
//    3 cycles after async rise: 2 sync + 1 register). Counter 0 w/o complete:
//    retry_cnt<MAX_RETRIES -> retry_cnt+1, RST_HOLD; else FAIL, err_code=1.
//    Complete and timeout on same cycle: complete wins.
//  - READY: ready=1, clk_en=1, rst_n=1. Synced apb_complete falling -> FAIL, err_code=1.
//  - FAIL: error=1, clk_en=0, rst_n=0, ready=0; err_code/retry_cnt held. Exit only by stop/rst.
//  - stop=1 in any state -> IDLE next edge (clk_en=0, rst_n=0, ready=0, error=0);
//    stop beats start, timeout, complete and cattrip on same cycle.
//  - ready and error never both 1. retry_cnt saturates at MAX_RETRIES, never wraps.
// CONFIGURATION
//  HBM_CATTRIP_EN defined: synced cattrip=1 in any state except IDLE/FAIL -> FAIL next
//    edge, err_code=2 (overrides code 1 on same cycle); clk_en and rst_n drop with it.
//  HBM_CATTRIP_EN undefined: cattrip port present but unused; err_code never 2.
// TESTING  (bench params: CLK_STABLE=8, RST_HOLD=4, CAL_TIMEOUT=20, MAX_RETRIES=2)
//  1 start@t0, apb_complete rises 5 cyc into CAL_WAIT -> clk_en high 8+4 cyc before rst_n
//    rises; ready=1 3 cyc after complete; retry_cnt=0, state_o=4.
//  2 apb_complete never -> 3 CAL_WAIT windows of 20 cyc each, each preceded by 4-cyc rst_n
//    low; then FAIL: error=1, err_code=1, retry_cnt=2, clk_en=0.
//  3 complete only during 2nd attempt -> READY with retry_cnt=1, error=0.
//  4 stop pulse in CAL_WAIT -> IDLE next edge, clk_en=0, rst_n=0; start+stop together
//    in IDLE -> stays IDLE; start in READY ignored.
//  5 HBM_CATTRIP_EN: cattrip in READY -> FAIL, err_code=2 within 3 cyc; stop -> IDLE;
//    without macro same stimulus -> READY unchanged.
//  6 rst asserted mid-RST_HOLD between edges -> all outputs to reset values immediately;
//    after release, start re-runs full sequence from CLK_ON.

Source files
------------

// File: rtl/hbm_init_sequencer.sv
// hbm_init_sequencer: HBM power-up, reset-hold and calibration-retry sequencer on the control clock.
// Optional feature macro HBM_CATTRIP_EN: a synchronised cattrip forces FAIL with err_code 2.
module hbm_init_sequencer #(
  parameter int unsigned CLK_STABLE_CYCLES  = 256,
  parameter int unsigned RST_HOLD_CYCLES    = 64,
  parameter int unsigned CAL_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned CNT_W              = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       apb_complete,
  input  logic       cattrip,
  output logic       hbm_clk_en,
  output logic       hbm_rst_n,
  output logic       ready,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLK_ON   = 3'd1,
    RST_HOLD = 3'd2,
    CAL_WAIT = 3'd3,
    READY    = 3'd4,
    FAIL     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CLK_LOAD  = CNT_W'(CLK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LOAD  = CNT_W'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       errCode_q, errCode_d;
  logic             clkEn_q, clkEn_d;
  logic             rstN_q, rstN_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic             apbMeta_q, apbSync_q;
  logic             catMeta_q, catSync_q;
  logic             catTrip;

`ifdef HBM_CATTRIP_EN
  assign catTrip = catSync_q;
`else
  logic unusedCatSync;
  assign unusedCatSync = catSync_q;
  assign catTrip       = 1'b0;
`endif

  // Next-state logic; stop overrides everything, cattrip overrides the normal transitions.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    retry_d   = retry_q;
    errCode_d = errCode_q;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = CLK_ON;
            retry_d   = '0;
            errCode_d = 2'd0;
            count_d   = CLK_LOAD;
          end
        end
        CLK_ON: begin
          if (count_q == '0) begin
            state_d = RST_HOLD;
            count_d = RST_LOAD;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        RST_HOLD: begin
          if (count_q == '0) begin
            state_d = CAL_WAIT;
            count_d = CAL_LOAD;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        CAL_WAIT: begin
          if (apbSync_q) begin
            state_d = READY;
          end else if (count_q == '0) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = RST_HOLD;
              count_d = RST_LOAD;
            end else begin
              state_d   = FAIL;
              errCode_d = 2'd1;
            end
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        READY: begin
          if (!apbSync_q) begin
            state_d   = FAIL;
            errCode_d = 2'd1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: state_d = IDLE;
      endcase
      if (catTrip && (state_q != IDLE) && (state_q != FAIL)) begin
        state_d   = FAIL;
        errCode_d = 2'd2;
      end
    end
    clkEn_d = (state_d == CLK_ON) || (state_d == RST_HOLD) ||
              (state_d == CAL_WAIT) || (state_d == READY);
    rstN_d  = (state_d == CAL_WAIT) || (state_d == READY);
    ready_d = (state_d == READY);
    error_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      retry_q   <= '0;
      errCode_q <= 2'd0;
      clkEn_q   <= 1'b0;
      rstN_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      apbMeta_q <= 1'b0;
      apbSync_q <= 1'b0;
      catMeta_q <= 1'b0;
      catSync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      retry_q   <= retry_d;
      errCode_q <= errCode_d;
      clkEn_q   <= clkEn_d;
      rstN_q    <= rstN_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      apbMeta_q <= apb_complete;
      apbSync_q <= apbMeta_q;
      catMeta_q <= cattrip;
      catSync_q <= catMeta_q;
    end
  end

  assign hbm_clk_en = clkEn_q;
  assign hbm_rst_n  = rstN_q;
  assign ready      = ready_q;
  assign error      = error_q;
  assign err_code   = errCode_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_hbm_init_sequencer.sv
// tb_hbm_init_sequencer: scoreboard bench for hbm_init_sequencer with short timing parameters.
// Expected output snapshots are queued with the stimulus and compared as their cycle arrives.
module tb_hbm_init_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       apbComplete;
  logic       cattrip;
  logic       hbmClkEn;
  logic       hbmRstN;
  logic       ready;
  logic       error;
  logic [1:0] errCode;
  logic [3:0] retryCnt;
  logic [2:0] stateO;

  typedef struct {
    int          cyc;
    logic [12:0] exp;
    logic [12:0] mask;
    string       tag;
  } expT;

  typedef struct {
    int   cyc;
    logic st;
    logic sp;
    logic apb;
    logic cat;
  } stimT;

  expT  sbQ[$];
  stimT stQ[$];
  int   cycle;
  int   compared;
  int   mismatched;

  hbm_init_sequencer #(
    .CLK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES   (4),
    .CAL_TIMEOUT_CYCLES(20),
    .MAX_RETRIES       (2),
    .CNT_W             (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .apb_complete(apbComplete),
    .cattrip     (cattrip),
    .hbm_clk_en  (hbmClkEn),
    .hbm_rst_n   (hbmRstN),
    .ready       (ready),
    .error       (error),
    .err_code    (errCode),
    .retry_cnt   (retryCnt),
    .state_o     (stateO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {stateO, hbmClkEn, hbmRstN, ready, error, errCode, retryCnt};
  endfunction

  function automatic void pushExp(input int c, input int s, input int ce, input int rn,
                                  input int rd, input int er, input int ec, input int rc,
                                  input string tag);
    expT e;
    e.cyc  = c;
    e.exp  = {3'(s), 1'(ce), 1'(rn), 1'(rd), 1'(er), 2'(ec), 4'(rc)};
    e.mask = '1;
    e.tag  = tag;
    sbQ.push_back(e);
  endfunction

  // IDLE after stop: err_code/retry_cnt are left out of the comparison.
  function automatic void pushIdle(input int c, input string tag);
    expT e;
    e.cyc  = c;
    e.exp  = '0;
    e.mask = 13'h1FC0;
    e.tag  = tag;
    sbQ.push_back(e);
  endfunction

  function automatic void pushStim(input int c, input int st, input int sp, input int apb, input int cat);
    stimT s;
    s.cyc = c;
    s.st  = 1'(st);
    s.sp  = 1'(sp);
    s.apb = 1'(apb);
    s.cat = 1'(cat);
    stQ.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus();
    stimT s;
    while (stQ.size() > 0 && stQ[0].cyc <= cycle) begin
      s           = stQ.pop_front();
      start       = s.st;
      stop        = s.sp;
      apbComplete = s.apb;
      cattrip     = s.cat;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    compared++;
    if (outs() !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_held: got %h want %h", outs(), 13'd0);
    end
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if (outs() !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_released_idle: got %h want %h", outs(), 13'd0);
    end
  endtask

  task automatic test_calibrate();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushStim(b + 18, 0, 0, 1, 0);
    pushStim(b + 26, 0, 1, 1, 0);
    pushStim(b + 27, 0, 0, 0, 0);
    pushExp(b + 1, 1, 1, 0, 0, 0, 0, 0, "t1_clkon_first");
    pushExp(b + 8, 1, 1, 0, 0, 0, 0, 0, "t1_clkon_last");
    pushExp(b + 9, 2, 1, 0, 0, 0, 0, 0, "t1_rsthold_first");
    pushExp(b + 12, 2, 1, 0, 0, 0, 0, 0, "t1_rsthold_last");
    pushExp(b + 13, 3, 1, 1, 0, 0, 0, 0, "t1_calwait");
    pushExp(b + 20, 3, 1, 1, 0, 0, 0, 0, "t1_sync_delay");
    pushExp(b + 21, 4, 1, 1, 1, 0, 0, 0, "t1_ready");
    pushExp(b + 26, 4, 1, 1, 1, 0, 0, 0, "t1_ready_hold");
    pushExp(b + 27, 0, 0, 0, 0, 0, 0, 0, "t1_stop_idle");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t1_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  task automatic test_retry_exhaust();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushStim(b + 83, 1, 0, 0, 0);
    pushStim(b + 84, 0, 0, 0, 0);
    pushStim(b + 86, 0, 1, 0, 0);
    pushStim(b + 87, 0, 0, 0, 0);
    pushExp(b + 13, 3, 1, 1, 0, 0, 0, 0, "t2_win1_first");
    pushExp(b + 32, 3, 1, 1, 0, 0, 0, 0, "t2_win1_last");
    pushExp(b + 33, 2, 1, 0, 0, 0, 0, 1, "t2_retry1_hold");
    pushExp(b + 36, 2, 1, 0, 0, 0, 0, 1, "t2_retry1_hold_end");
    pushExp(b + 37, 3, 1, 1, 0, 0, 0, 1, "t2_win2_first");
    pushExp(b + 56, 3, 1, 1, 0, 0, 0, 1, "t2_win2_last");
    pushExp(b + 57, 2, 1, 0, 0, 0, 0, 2, "t2_retry2_hold");
    pushExp(b + 61, 3, 1, 1, 0, 0, 0, 2, "t2_win3_first");
    pushExp(b + 80, 3, 1, 1, 0, 0, 0, 2, "t2_win3_last");
    pushExp(b + 81, 5, 0, 0, 0, 1, 1, 2, "t2_fail");
    pushExp(b + 85, 5, 0, 0, 0, 1, 1, 2, "t2_fail_start_ignored");
    pushIdle(b + 87, "t2_stop_idle");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t2_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  task automatic test_second_attempt();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushStim(b + 40, 0, 0, 1, 0);
    pushStim(b + 45, 0, 0, 0, 0);
    pushStim(b + 49, 0, 1, 0, 0);
    pushStim(b + 50, 0, 0, 0, 0);
    pushExp(b + 32, 3, 1, 1, 0, 0, 0, 0, "t3_win1_last");
    pushExp(b + 33, 2, 1, 0, 0, 0, 0, 1, "t3_retry1");
    pushExp(b + 42, 3, 1, 1, 0, 0, 0, 1, "t3_sync_delay");
    pushExp(b + 43, 4, 1, 1, 1, 0, 0, 1, "t3_ready_retry1");
    pushExp(b + 47, 4, 1, 1, 1, 0, 0, 1, "t3_ready_hold");
    pushExp(b + 48, 5, 0, 0, 0, 1, 1, 1, "t3_apb_drop_fail");
    pushIdle(b + 50, "t3_stop_idle");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t3_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  task automatic test_stop();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushStim(b + 15, 0, 1, 0, 0);
    pushStim(b + 16, 0, 0, 0, 0);
    pushStim(b + 18, 1, 1, 0, 0);
    pushStim(b + 19, 0, 0, 0, 0);
    pushStim(b + 22, 1, 0, 0, 0);
    pushStim(b + 23, 0, 0, 1, 0);
    pushStim(b + 38, 1, 0, 1, 0);
    pushStim(b + 39, 0, 0, 1, 0);
    pushStim(b + 41, 0, 1, 1, 0);
    pushStim(b + 42, 0, 0, 0, 0);
    pushExp(b + 15, 3, 1, 1, 0, 0, 0, 0, "t4_calwait");
    pushExp(b + 16, 0, 0, 0, 0, 0, 0, 0, "t4_stop_idle");
    pushExp(b + 19, 0, 0, 0, 0, 0, 0, 0, "t4_start_stop_idle");
    pushExp(b + 21, 0, 0, 0, 0, 0, 0, 0, "t4_idle_hold");
    pushExp(b + 35, 3, 1, 1, 0, 0, 0, 0, "t4_calwait2");
    pushExp(b + 36, 4, 1, 1, 1, 0, 0, 0, "t4_ready_presynced");
    pushExp(b + 40, 4, 1, 1, 1, 0, 0, 0, "t4_start_in_ready");
    pushExp(b + 42, 0, 0, 0, 0, 0, 0, 0, "t4_stop_ready");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t4_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  task automatic test_cattrip();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 1, 0);
    pushStim(b + 16, 0, 0, 1, 1);
    pushStim(b + 20, 0, 1, 0, 0);
    pushStim(b + 21, 0, 0, 0, 0);
    pushExp(b + 14, 4, 1, 1, 1, 0, 0, 0, "t5_ready");
    pushExp(b + 18, 4, 1, 1, 1, 0, 0, 0, "t5_ready_presync");
`ifdef HBM_CATTRIP_EN
    pushExp(b + 19, 5, 0, 0, 0, 1, 2, 0, "t5_cattrip_fail");
`else
    pushExp(b + 19, 4, 1, 1, 1, 0, 0, 0, "t5_cattrip_ignored");
`endif
    pushIdle(b + 21, "t5_stop_idle");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t5_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  task automatic test_async_reset();
    expT e;
    int  b;
    int  limit;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushExp(b + 9, 2, 1, 0, 0, 0, 0, 0, "t6_rsthold");
    pushExp(b + 10, 2, 1, 0, 0, 0, 0, 0, "t6_rsthold_mid");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    // Reset lands between clock edges; outputs must clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (outs() !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL t6_async_reset: got %h want %h", outs(), 13'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    b = cycle;
    pushStim(b, 1, 0, 0, 0);
    pushStim(b + 1, 0, 0, 0, 0);
    pushStim(b + 14, 0, 1, 0, 0);
    pushStim(b + 15, 0, 0, 0, 0);
    pushExp(b + 1, 1, 1, 0, 0, 0, 0, 0, "t6_rerun_clkon");
    pushExp(b + 8, 1, 1, 0, 0, 0, 0, 0, "t6_rerun_clkon_last");
    pushExp(b + 9, 2, 1, 0, 0, 0, 0, 0, "t6_rerun_rsthold");
    pushExp(b + 13, 3, 1, 1, 0, 0, 0, 0, "t6_rerun_calwait");
    pushExp(b + 15, 0, 0, 0, 0, 0, 0, 0, "t6_rerun_stop");
    applyStimulus();
    limit = cycle + 200;
    while ((sbQ.size() > 0 || stQ.size() > 0) && cycle < limit) begin
      tick();
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
        e = sbQ.pop_front();
        compared++;
        if ((outs() & e.mask) !== (e.exp & e.mask)) begin
          mismatched++;
          $display("[TB] FAIL %s @%0d: got %h want %h", e.tag, cycle, outs() & e.mask, e.exp & e.mask);
        end
      end
      applyStimulus();
    end
    if (sbQ.size() > 0 || stQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t6_budget: got %0d pending want 0", sbQ.size() + stQ.size());
      sbQ.delete();
      stQ.delete();
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    apbComplete = 1'b0;
    cattrip     = 1'b0;
    cycle       = 0;
    compared    = 0;
    mismatched  = 0;
    test_reset();
    test_calibrate();
    test_retry_exhaust();
    test_second_attempt();
    test_stop();
    test_cattrip();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
